// File: rtl/pseudo_pkg.sv
// Shared types and constants for the pseudo busy-unit array.
package pseudo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_e;

  localparam int MODE_IGNORE  = 0;
  localparam int MODE_RESTART = 1;

endpackage

// File: rtl/pseudo_busy_array_if.sv
// Bundle of the per-channel start/length inputs and status outputs.
// Handshake: Start[c] is a one-cycle request with BusyCycles[c] as its payload;
// there is no ready - a request is taken when channel c is IDLE/DONE (or RUN in
// restart mode), otherwise it is dropped and recorded in Overrun[c].
interface pseudo_busy_array_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       Start;
  logic [CHANNELS*CNT_W-1:0] BusyCycles;
  logic [CHANNELS-1:0]       Busy;
  logic [CHANNELS-1:0]       End;
  logic [CHANNELS-1:0]       Overrun;
  logic                      AllIdle;

  modport master (
    output Start, BusyCycles,
    input  Busy, End, Overrun, AllIdle
  );

  modport slave (
    input  Start, BusyCycles,
    output Busy, End, Overrun, AllIdle
  );
endinterface

// File: rtl/pseudo_busy_chan.sv
// One fake processing unit: IDLE -> RUN for N cycles -> one-cycle DONE.
// The state register is exported on state_o for the array summary and for debug.
module pseudo_busy_chan
  import pseudo_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RETRIGGER = MODE_IGNORE
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cycles_i,
  output logic             busy_o,
  output logic             end_o,
  output logic             overrun_o,
  output chan_state_e      state_o
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             end_q, end_d;
  logic             load;

  // A start is taken outside RUN always, and inside RUN only in restart mode.
  assign load = start_i && ((state_q != ST_RUN) || (RETRIGGER == MODE_RESTART));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    if ((RETRIGGER == MODE_IGNORE) && start_i && (state_q == ST_RUN)) begin
      overrun_d = 1'b1;
    end
    if (load) begin
      if (cycles_i == '0) begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end else begin
        state_d = ST_RUN;
        cnt_d   = cycles_i;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so Busy/End come straight off flops.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    end_d  = (state_d == ST_DONE);
  end

  assign busy_o    = busy_q;
  assign end_o     = end_q;
  assign overrun_o = overrun_q;
  assign state_o   = state_q;

endmodule

// File: rtl/pseudo_busy_array.sv
// Array of independent fake busy units with an all-idle summary.
module pseudo_busy_array
  import pseudo_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int RETRIGGER = MODE_IGNORE
) (
  input  logic                Clock,
  input  logic                Reset,
  pseudo_busy_array_if.slave  bus
);

  logic [CHANNELS-1:0] busy_v;
  logic [CHANNELS-1:0] end_v;
  logic [CHANNELS-1:0] overrun_v;
  logic [CHANNELS-1:0] idle_v;
  chan_state_e         state_v [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pseudo_busy_chan #(
      .CNT_W     (CNT_W),
      .RETRIGGER (RETRIGGER)
    ) u_chan (
      .Clock     (Clock),
      .Reset     (Reset),
      .start_i   (bus.Start[c]),
      .cycles_i  (bus.BusyCycles[c*CNT_W +: CNT_W]),
      .busy_o    (busy_v[c]),
      .end_o     (end_v[c]),
      .overrun_o (overrun_v[c]),
      .state_o   (state_v[c])
    );
    // DONE counts as not idle: its End pulse is still pending.
    assign idle_v[c] = (state_v[c] == ST_IDLE);
  end

  assign bus.Busy    = busy_v;
  assign bus.End     = end_v;
  assign bus.Overrun = overrun_v;
  assign bus.AllIdle = &idle_v;

endmodule

// File: tb/tb_pseudo_busy_array.sv
// Bench for pseudo_busy_array: one instance per retrigger mode, driven in lockstep.
module tb_pseudo_busy_array;
  import pseudo_pkg::*;

  localparam int CH = 4;
  localparam int W  = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pseudo_busy_array_if #(.CHANNELS(CH), .CNT_W(W)) bus0 ();
  pseudo_busy_array_if #(.CHANNELS(CH), .CNT_W(W)) bus1 ();

  pseudo_busy_array #(.CHANNELS(CH), .CNT_W(W), .RETRIGGER(MODE_IGNORE)) dut0 (
    .Clock (Clock), .Reset (Reset), .bus (bus0.slave));
  pseudo_busy_array #(.CHANNELS(CH), .CNT_W(W), .RETRIGGER(MODE_RESTART)) dut1 (
    .Clock (Clock), .Reset (Reset), .bus (bus1.slave));

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (per accepted start: start time and length) ----------------
  int t = 0;
  bit m_act [2][CH];
  int m_st  [2][CH];
  int m_len [2][CH];
  bit m_ovr [2][CH];

  function automatic bit m_busy(int m, int c, int tt);
    return m_act[m][c] && (tt >= m_st[m][c]) && (tt < m_st[m][c] + m_len[m][c]);
  endfunction

  function automatic bit m_end(int m, int c, int tt);
    return m_act[m][c] && (tt == m_st[m][c] + m_len[m][c]);
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        m_act[m][c] = 1'b0;
        m_ovr[m][c] = 1'b0;
      end
  endtask

  task automatic model_edge(input logic [CH-1:0] s, input logic [CH*W-1:0] n);
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++)
        if (s[c]) begin
          if (m == 1 || !m_busy(m, c, t - 1)) begin
            m_act[m][c] = 1'b1;
            m_st[m][c]  = t;
            m_len[m][c] = int'(n[c*W +: W]);
          end else begin
            m_ovr[m][c] = 1'b1;
          end
        end
  endtask

  function automatic logic [CH-1:0] exp_busy(int m);
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c] = m_busy(m, c, t);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_end(int m);
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c] = m_end(m, c, t);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_ovr(int m);
    logic [CH-1:0] r = '0;
    for (int c = 0; c < CH; c++) r[c] = m_ovr[m][c];
    return r;
  endfunction

  // ---------------- checker / drivers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %0h, required %0h", name, t, act, exp);
    end
  endtask

  task automatic drive(input logic [CH-1:0] s, input logic [CH*W-1:0] n);
    bus0.Start = s; bus0.BusyCycles = n;
    bus1.Start = s; bus1.BusyCycles = n;
  endtask

  // Drive at the falling edge, let the rising edge sample, look 1 ns later.
  task automatic step(input logic [CH-1:0] s, input logic [CH*W-1:0] n);
    @(negedge Clock);
    drive(s, n);
    @(posedge Clock);
    t++;
    model_edge(s, n);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_busy0"}, 32'(bus0.Busy),    32'(exp_busy(0)));
    chk({tag, "_end0"},  32'(bus0.End),     32'(exp_end(0)));
    chk({tag, "_ovr0"},  32'(bus0.Overrun), 32'(exp_ovr(0)));
    chk({tag, "_idle0"}, 32'(bus0.AllIdle), 32'((exp_busy(0) | exp_end(0)) == '0));
    chk({tag, "_busy1"}, 32'(bus1.Busy),    32'(exp_busy(1)));
    chk({tag, "_end1"},  32'(bus1.End),     32'(exp_end(1)));
    chk({tag, "_ovr1"},  32'(bus1.Overrun), 32'(exp_ovr(1)));
    chk({tag, "_idle1"}, 32'(bus1.AllIdle), 32'((exp_busy(1) | exp_end(1)) == '0));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy0"}, 32'(bus0.Busy),    32'h0);
    chk({tag, "_end0"},  32'(bus0.End),     32'h0);
    chk({tag, "_ovr0"},  32'(bus0.Overrun), 32'h0);
    chk({tag, "_idle0"}, 32'(bus0.AllIdle), 32'h1);
    chk({tag, "_busy1"}, 32'(bus1.Busy),    32'h0);
    chk({tag, "_end1"},  32'(bus1.End),     32'h0);
    chk({tag, "_idle1"}, 32'(bus1.AllIdle), 32'h1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    model_clear();
    #1;
    check_quiet(tag);
    @(negedge Clock);
    drive('0, '0);
    @(posedge Clock);
    #1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [CH-1:0]   start;
    logic [CH*W-1:0] cyc;
    logic [CH-1:0]   busy0, end0, ovr0;
    logic            idle0;
    logic [CH-1:0]   busy1, end1;
    logic            idle1;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic [3:0] s, logic [31:0] n,
                              logic [3:0] b0, logic [3:0] e0, logic [3:0] o0, logic i0,
                              logic [3:0] b1, logic [3:0] e1, logic i1);
    vec_t v;
    v.start = s; v.cyc = n;
    v.busy0 = b0; v.end0 = e0; v.ovr0 = o0; v.idle0 = i0;
    v.busy1 = b1; v.end1 = e1; v.idle1 = i1;
    return v;
  endfunction

  initial begin
    int bc0, bc1;
    bit ended;
    logic [CH-1:0]   rs;
    logic [CH*W-1:0] rn;

    // ch0 N=3
    vecs[0]  = mk(4'h1, 32'd3, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[1]  = mk(4'h0, 32'd0, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[2]  = mk(4'h0, 32'd0, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[3]  = mk(4'h0, 32'd0, 4'h0, 4'h1, 4'h0, 0, 4'h0, 4'h1, 0);
    vecs[4]  = mk(4'h0, 32'd0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1);
    // ch1 N=0
    vecs[5]  = mk(4'h2, 32'd0, 4'h0, 4'h2, 4'h0, 0, 4'h0, 4'h2, 0);
    vecs[6]  = mk(4'h0, 32'd0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1);
    // ch0 N=1, then start N=2 while End is high
    vecs[7]  = mk(4'h1, 32'd1, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[8]  = mk(4'h0, 32'd0, 4'h0, 4'h1, 4'h0, 0, 4'h0, 4'h1, 0);
    vecs[9]  = mk(4'h1, 32'd2, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[10] = mk(4'h0, 32'd0, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[11] = mk(4'h0, 32'd0, 4'h0, 4'h1, 4'h0, 0, 4'h0, 4'h1, 0);
    vecs[12] = mk(4'h0, 32'd0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1);
    // ch0 N=5, second start N=4 two cycles later
    vecs[13] = mk(4'h1, 32'd5, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[14] = mk(4'h0, 32'd0, 4'h1, 4'h0, 4'h0, 0, 4'h1, 4'h0, 0);
    vecs[15] = mk(4'h1, 32'd4, 4'h1, 4'h0, 4'h1, 0, 4'h1, 4'h0, 0);
    vecs[16] = mk(4'h0, 32'd0, 4'h1, 4'h0, 4'h1, 0, 4'h1, 4'h0, 0);
    vecs[17] = mk(4'h0, 32'd0, 4'h1, 4'h0, 4'h1, 0, 4'h1, 4'h0, 0);
    vecs[18] = mk(4'h0, 32'd0, 4'h0, 4'h1, 4'h1, 0, 4'h1, 4'h0, 0);
    vecs[19] = mk(4'h0, 32'd0, 4'h0, 4'h0, 4'h1, 1, 4'h0, 4'h1, 0);
    vecs[20] = mk(4'h0, 32'd0, 4'h0, 4'h0, 4'h1, 1, 4'h0, 4'h0, 1);
    // all channels, N=1,2,3,4
    vecs[21] = mk(4'hF, 32'h04030201, 4'hF, 4'h0, 4'h1, 0, 4'hF, 4'h0, 0);
    vecs[22] = mk(4'h0, 32'd0,        4'hE, 4'h1, 4'h1, 0, 4'hE, 4'h1, 0);
    vecs[23] = mk(4'h0, 32'd0,        4'hC, 4'h2, 4'h1, 0, 4'hC, 4'h2, 0);

    drive('0, '0);
    model_clear();
    repeat (2) @(posedge Clock);
    #1;
    check_quiet("reset");
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      string tag;
      step(vecs[i].start, vecs[i].cyc);
      tag = $sformatf("vec%0d", i);
      chk({tag, "_busy0"}, 32'(bus0.Busy),    32'(vecs[i].busy0));
      chk({tag, "_end0"},  32'(bus0.End),     32'(vecs[i].end0));
      chk({tag, "_ovr0"},  32'(bus0.Overrun), 32'(vecs[i].ovr0));
      chk({tag, "_idle0"}, 32'(bus0.AllIdle), 32'(vecs[i].idle0));
      chk({tag, "_busy1"}, 32'(bus1.Busy),    32'(vecs[i].busy1));
      chk({tag, "_end1"},  32'(bus1.End),     32'(vecs[i].end1));
      chk({tag, "_ovr1"},  32'(bus1.Overrun), 32'h0);
      chk({tag, "_idle1"}, 32'(bus1.AllIdle), 32'(vecs[i].idle1));
    end

    // Reset in the middle of the four-channel run: no End may follow.
    do_reset("midrun_reset");
    for (int i = 0; i < 5; i++) begin
      step('0, '0);
      check_quiet($sformatf("post_reset%0d", i));
    end

    // Maximum length; BusyCycles keeps changing while the count runs.
    step(4'b0100, {8'd0, 8'd255, 16'd0});
    bc0 = 0; bc1 = 0; ended = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus0.End[2]) begin
        ended = 1'b1;
        break;
      end
      if (bus0.Busy[2]) bc0++;
      if (bus1.Busy[2]) bc1++;
      step('0, $urandom);
    end
    chk("maxlen_end_seen", 32'(ended), 32'h1);
    chk("maxlen_busy0", 32'(bc0), 32'd255);
    chk("maxlen_busy1", 32'(bc1), 32'd255);
    check_model("maxlen_end");
    step('0, '0);
    check_model("maxlen_after");

    // Random traffic against the model, with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        rs[c] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) rn[c*W +: W] = W'($urandom_range(0, 255));
        else                            rn[c*W +: W] = W'($urandom_range(0, 6));
      end
      step(rs, rn);
      check_model("rand");
      if ($urandom_range(0, 249) == 0) do_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pseudo_busy_array.md
# pseudo_busy_array

Synthesizable, parametrised multi-channel stand-in for processing blocks that are not yet available, used in simulation benches and FPGA bring-up builds. Each channel accepts a one-cycle Start pulse, holds Busy high for a per-start programmable number of Clock cycles, then emits a one-cycle End pulse. It supports a selectable retrigger mode, sticky overrun flags and an all-idle summary, so sequencers can be exercised against several concurrent fake units.

## Interface
Parameters:
- CHANNELS, 4, number of independent channels (1..16)
- CNT_W, 8, width of the per-channel busy-cycle count
- RETRIGGER, 0, 0 = ignore Start while busy and flag overrun; 1 = restart the countdown with the new length

Ports:
- Clock  in  1  single clock for the whole block
- Reset  in  1  asynchronous, active-high reset
- Start  in  CHANNELS  per-channel start pulse, sampled on rising Clock
- BusyCycles  in  CHANNELS*CNT_W  per-channel busy length, channel c at [c*CNT_W +: CNT_W], sampled together with Start
- Busy  out  CHANNELS  per-channel busy indicator
- End  out  CHANNELS  per-channel one-cycle completion pulse
- Overrun  out  CHANNELS  sticky flag: Start arrived while busy and was dropped (RETRIGGER=0 only)
- AllIdle  out  1  high when no Busy bit is set and no End is pending

## Operation
- Per-channel states: IDLE, RUN, DONE.
- IDLE: on Start=1 with BusyCycles=N:
  - N>0: load the counter with N and go to RUN.
  - N=0: go directly to DONE. No Busy cycle occurs.
- RUN: Busy=1. The counter decrements every cycle. When it reaches 1, the next state is DONE.
- DONE: End=1 and Busy=0 for exactly one cycle, then IDLE. A Start during DONE is accepted exactly as in IDLE, so back-to-back operations run without a gap.
- Start while in RUN:
  - RETRIGGER=0: the Start is ignored, Overrun[c] is set, and the current countdown continues unchanged.
  - RETRIGGER=1: the counter is reloaded with the new N and no End is emitted for the aborted operation. If N=0, go to DONE next.
- Overrun bits stay set until Reset. They are constant 0 when RETRIGGER=1.
- AllIdle = all channels in IDLE (combinational decode of registered state).
- Channels are fully independent. Simultaneous Starts on several channels are all accepted.

## Timing
- Reset (asynchronous, any time, including mid-RUN): all channels go to IDLE; Busy=0, End=0, Overrun=0, AllIdle=1, counters=0. No End is emitted for aborted operations.
- Start sampled at edge k with N>0:
  - Busy is high after edges k..k+N-1, i.e. exactly N cycles.
  - End is high for the one cycle after edge k+N, coincident with the first Busy-low cycle.
- Start at edge k with N=0: End is high for the one cycle after edge k.
- All outputs are registered except AllIdle.
- BusyCycles is only sampled on accepted Starts. Later changes do not affect a running count.
- Counter arithmetic is unsigned CNT_W bits. N=2^CNT_W-1 is the maximum length; there is no wrap.

## Structure
- Shared package pseudo_pkg:
  - state encoding typedef (IDLE/RUN/DONE)
  - RETRIGGER mode constants MODE_IGNORE=0, MODE_RESTART=1
- Sub-module pseudo_busy_chan: one channel containing its state machine, counter and overrun flag, parametrised by CNT_W and RETRIGGER.
- pseudo_busy_array is a generate loop over CHANNELS plus the AllIdle reduction.

## Test plan
- Reset, then Start[0] with N=3: Busy[0] is high for 3 cycles; End[0] pulses once on the 4th cycle; AllIdle returns to 1 the cycle after End.
- N=0 on channel 1: no Busy[1]; End[1] is high in the cycle after Start.
- RETRIGGER=0, N=5, second Start at cycle 2: Busy stays 5 cycles total; Overrun[0]=1 and stays set; only one End.
- RETRIGGER=1, N=5, restart at cycle 2 with N=4: Busy totals 6 cycles; one End.
- Start asserted in the End cycle with N=2: End and then Busy=1 with no gap; 2 busy cycles followed by a second End.
- All 4 channels started together with N=1,2,3,4 and Reset asserted mid-run at cycle 2: all outputs are 0 immediately; no End pulses; AllIdle=1.
